// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding and default sizing for the burst memory controller.
package mem_ctrl_pkg;

   localparam int unsigned DEF_ADDR_SIZE      = 32;
   localparam int unsigned DEF_WORD_SIZE      = 32;
   localparam int unsigned DEF_STROBE_BITS    = 4;
   localparam int unsigned DEF_BURST_BITS     = 2;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

   // Byte distance between consecutive beats of a burst.
   localparam int unsigned BEAT_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_RESP
   } state_t;

endpackage

// File: rtl/mem_beat_timer.sv
// Per-beat watchdog: counts cycles while the memory handshake is pending and
// flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
module mem_beat_timer
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   assign expired = enable && (count == LIMIT);

   // Wait-cycle counter, restarted whenever the controller is not waiting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst command controller in front of a byte-banked memory: splits a burst
// into word beats, strobes each beat once, waits on the memory busy handshake
// and returns per-beat read responses or a single write completion.
module mem_burst_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_SIZE      = DEF_ADDR_SIZE,
   parameter int unsigned WORD_SIZE      = DEF_WORD_SIZE,
   parameter int unsigned STROBE_BITS    = DEF_STROBE_BITS,
   parameter int unsigned BURST_BITS     = DEF_BURST_BITS,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   reqValid,
   output logic                   reqReady,
   input  logic [ADDR_SIZE-1:0]   reqAddr,
   input  logic                   reqWr,
   input  logic [STROBE_BITS-1:0] reqStrb,
   input  logic [BURST_BITS-1:0]  reqBurstLen,
   input  logic                   wValid,
   output logic                   wReady,
   input  logic [WORD_SIZE-1:0]   wData,
   output logic                   rspValid,
   input  logic                   rspReady,
   output logic [WORD_SIZE-1:0]   rspData,
   output logic                   rspLast,
   output logic                   rspWr,
   output logic                   rspErr,
   output logic [ADDR_SIZE-1:0]   memAddr,
   output logic [WORD_SIZE-1:0]   memDataIn,
   output logic [STROBE_BITS-1:0] memStrb,
   output logic                   memWr,
   output logic [BURST_BITS-1:0]  memBurstLen,
   input  logic                   memBusyOut,
   input  logic [WORD_SIZE-1:0]   memDataOut
);

   state_t state, state_n;

   logic [ADDR_SIZE-1:0]   addr_q;
   logic                   wr_q;
   logic [STROBE_BITS-1:0] strb_q;
   logic [BURST_BITS-1:0]  len_q;
   logic [BURST_BITS-1:0]  cnt_q;
   logic [WORD_SIZE-1:0]   wdata_q;
   logic [WORD_SIZE-1:0]   rdata_q;
   logic                   err_q;

   logic                   accept;
   logic                   wlatch;
   logic                   capture;
   logic                   advance;
   logic                   waiting;
   logic                   tmo;
   logic                   last_beat;
   logic                   no_access;
   logic [WORD_SIZE-1:0]   lane_mask;

   assign last_beat = (cnt_q == '0);
   assign no_access = (strb_q == '0);
   assign waiting   = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);

   mem_beat_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (!waiting),
      .enable (waiting),
      .expired(tmo)
   );

   // Expand the latched byte strobe into a per-bit read-data mask.
   always_comb begin
      lane_mask = '0;
      for (int unsigned i = 0; i < STROBE_BITS; i++) begin
         lane_mask[i*8 +: 8] = {8{strb_q[i]}};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode and datapath control strobes.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      wlatch  = 1'b0;
      capture = 1'b0;
      advance = 1'b0;
      case (state)
         ST_IDLE: begin
            if (reqValid) begin
               accept = 1'b1;
               if (reqWr) begin
                  state_n = ST_WDATA;
               end else if (reqStrb == '0) begin
                  state_n = ST_RESP;
               end else begin
                  state_n = ST_ISSUE;
               end
            end
         end
         ST_WDATA: begin
            if (wValid) begin
               wlatch = 1'b1;
               // A zero-strobe beat never touches memory; it just consumes data.
               if (!no_access) begin
                  state_n = ST_ISSUE;
               end else if (last_beat) begin
                  state_n = ST_RESP;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            state_n = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tmo) begin
               state_n = ST_RESP;
            end else if (memBusyOut) begin
               state_n = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (tmo) begin
               state_n = ST_RESP;
            end else if (!memBusyOut) begin
               capture = 1'b1;
               if (!wr_q || last_beat) begin
                  state_n = ST_RESP;
               end else begin
                  advance = 1'b1;
                  state_n = ST_WDATA;
               end
            end
         end
         ST_RESP: begin
            if (rspReady) begin
               if (err_q || last_beat) begin
                  state_n = ST_IDLE;
               end else begin
                  advance = 1'b1;
                  state_n = no_access ? ST_RESP : ST_ISSUE;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Command latch, beat address/count progression and response capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wr_q    <= 1'b0;
         strb_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= reqAddr;
            wr_q    <= reqWr;
            strb_q  <= reqStrb;
            len_q   <= reqBurstLen;
            cnt_q   <= reqBurstLen;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
         if (wlatch) begin
            wdata_q <= wData;
         end
         if (capture) begin
            rdata_q <= wr_q ? '0 : (memDataOut & lane_mask);
         end
         if (tmo) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
         if (advance) begin
            addr_q <= addr_q + ADDR_SIZE'(BEAT_BYTES);
            cnt_q  <= cnt_q - BURST_BITS'(1);
         end
      end
   end

   // reqReady is gated by reset so every output reads 0 while reset is held.
   assign reqReady    = (state == ST_IDLE) && reset;
   assign wReady      = (state == ST_WDATA);
   assign memStrb     = (state == ST_ISSUE) ? strb_q : '0;
   assign memAddr     = {addr_q[ADDR_SIZE-1:2], 2'b00};
   assign memWr       = wr_q;
   assign memDataIn   = wdata_q;
   assign memBurstLen = len_q;
   assign rspValid    = (state == ST_RESP);
   assign rspData     = rspValid ? rdata_q : '0;
   assign rspLast     = rspValid && (err_q || last_beat);
   assign rspWr       = rspValid && wr_q;
   assign rspErr      = rspValid && err_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a behavioural byte-banked memory.
module tb_mem_burst_ctrl;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic [31:0] reqAddr = '0;
   logic        reqWr = 1'b0;
   logic [3:0]  reqStrb = '0;
   logic [1:0]  reqBurstLen = '0;
   logic        wValid = 1'b0;
   logic        wReady;
   logic [31:0] wData = '0;
   logic        rspValid;
   logic        rspReady = 1'b0;
   logic [31:0] rspData;
   logic        rspLast, rspWr, rspErr;
   logic [31:0] memAddr, memDataIn;
   logic [3:0]  memStrb;
   logic        memWr;
   logic [1:0]  memBurstLen;
   logic        memBusyOut = 1'b0;
   logic [31:0] memDataOut = '0;

   logic [108:0] all_out;
   assign all_out = {reqReady, wReady, rspValid, rspData, rspLast, rspWr, rspErr,
                     memAddr, memDataIn, memStrb, memWr, memBurstLen};

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        wr;
      logic        err;
   } rsp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic        wr;
      logic [31:0] data;
   } acc_t;

   rsp_t        exp_q[$];
   acc_t        acc_q[$];
   logic [31:0] mem     [0:255] = '{default: '0};
   logic [31:0] ref_mem [0:255] = '{default: '0};
   int          checks = 0;
   int          failures = 0;
   int          strb_cycles = 0;
   bit          busy_tie0 = 1'b0;

   mem_burst_ctrl #(
      .ADDR_SIZE     (32),
      .WORD_SIZE     (32),
      .STROBE_BITS   (4),
      .BURST_BITS    (2),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .reqValid   (reqValid),
      .reqReady   (reqReady),
      .reqAddr    (reqAddr),
      .reqWr      (reqWr),
      .reqStrb    (reqStrb),
      .reqBurstLen(reqBurstLen),
      .wValid     (wValid),
      .wReady     (wReady),
      .wData      (wData),
      .rspValid   (rspValid),
      .rspReady   (rspReady),
      .rspData    (rspData),
      .rspLast    (rspLast),
      .rspWr      (rspWr),
      .rspErr     (rspErr),
      .memAddr    (memAddr),
      .memDataIn  (memDataIn),
      .memStrb    (memStrb),
      .memWr      (memWr),
      .memBurstLen(memBurstLen),
      .memBusyOut (memBusyOut),
      .memDataOut (memDataOut)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mask(input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
      return m;
   endfunction

   // Memory: a strobed cycle performs the access and raises busy for one cycle.
   always @(posedge clk) begin
      if (memStrb != '0) begin
         strb_cycles <= strb_cycles + 1;
         acc_q.push_back('{memAddr, memStrb, memWr, memDataIn});
         mem[memAddr[9:2]] <= memWr ? merge(mem[memAddr[9:2]], memDataIn, memStrb)
                                    : mem[memAddr[9:2]];
         memDataOut <= memWr ? merge(mem[memAddr[9:2]], memDataIn, memStrb)
                             : mem[memAddr[9:2]];
      end
      memBusyOut <= (memStrb != '0) && !busy_tie0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers (all start and end on a negedge) -------
   task automatic send_cmd(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [1:0] l);
      int n;
      n = 0;
      reqAddr = a; reqWr = w; reqStrb = s; reqBurstLen = l; reqValid = 1'b1;
      while (!reqReady && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!reqReady) begin
         failures++;
         $display("FAIL cmd_accept: reqReady=%b required 1 within 100 cycles", reqReady);
      end
      @(negedge clk);
      reqValid = 1'b0;
   endtask

   task automatic send_wdata(input logic [31:0] d);
      int n;
      n = 0;
      wData = d; wValid = 1'b1;
      while (!wReady && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!wReady) begin
         failures++;
         $display("FAIL wdata_accept: wReady=%b required 1 within 100 cycles", wReady);
      end
      @(negedge clk);
      wValid = 1'b0;
   endtask

   task automatic get_rsp(output rsp_t r);
      int n;
      n = 0;
      while (!rspValid && n < 100) begin @(negedge clk); n++; end
      if (!rspValid) begin
         r = '1;
         return;
      end
      r = '{rspData, rspLast, rspWr, rspErr};
      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
   endtask

   task automatic push_read(input logic [31:0] a, input logic [3:0] s, input int l);
      logic [31:0] ba;
      for (int b = 0; b <= l; b++) begin
         ba = a + 32'(4 * b);
         exp_q.push_back('{(s == '0) ? 32'h0 : (ref_mem[ba[9:2]] & mask(s)), b == l, 1'b0, 1'b0});
      end
   endtask

   task automatic ref_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
   endtask

   // ---------------- tests ----------------------------------------------------
   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h required 0", all_out);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (reqReady !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: reqReady=%b required 1", reqReady);
      end
      @(negedge clk);
   endtask

   task automatic test_single_write;
      rsp_t r, e;
      int   s0;
      s0 = strb_cycles;
      acc_q.delete();
      ref_write(32'h100, 4'hF, 32'hDEADBEEF);
      exp_q.push_back('{32'h0, 1'b1, 1'b1, 1'b0});
      send_cmd(32'h100, 1'b1, 4'hF, 2'd0);
      send_wdata(32'hDEADBEEF);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL single_write_rsp: got %h required %h", r, e);
      end
      checks++;
      if (strb_cycles - s0 !== 1) begin
         failures++;
         $display("FAIL single_write_pulses: got %0d required 1", strb_cycles - s0);
      end
      checks++;
      if (acc_q.size() != 1 || acc_q[0] !== acc_t'({32'h100, 4'hF, 1'b1, 32'hDEADBEEF})) begin
         failures++;
         $display("FAIL single_write_access: got n=%0d first=%h required 1 access %h",
                  acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : '0,
                  acc_t'({32'h100, 4'hF, 1'b1, 32'hDEADBEEF}));
      end
   endtask

   task automatic test_burst_rw;
      logic [31:0] wd [4];
      rsp_t r, e;
      wd = '{32'hDEADBEEF, 32'h12345678, 32'hA5A55A5A, 32'h0F0FF0F0};
      acc_q.delete();
      for (int b = 0; b < 4; b++) ref_write(32'h100 + 32'(4 * b), 4'hF, wd[b]);
      exp_q.push_back('{32'h0, 1'b1, 1'b1, 1'b0});
      send_cmd(32'h100, 1'b1, 4'hF, 2'd3);
      for (int b = 0; b < 4; b++) send_wdata(wd[b]);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL burst_write_rsp: got %h required %h", r, e);
      end
      checks++;
      if (rspValid !== 1'b0) begin
         failures++;
         $display("FAIL burst_write_single_rsp: rspValid=%b required 0", rspValid);
      end
      acc_q.delete();
      push_read(32'h100, 4'hF, 3);
      send_cmd(32'h100, 1'b0, 4'hF, 2'd3);
      for (int b = 0; b < 4; b++) begin
         get_rsp(r);
         e = exp_q.pop_front();
         checks++;
         if (r !== e) begin
            failures++;
            $display("FAIL burst_read_rsp%0d: got %h required %h", b, r, e);
         end
      end
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (acc_q.size() <= b || acc_q[b].addr !== 32'h100 + 32'(4 * b) || acc_q[b].wr !== 1'b0) begin
            failures++;
            $display("FAIL burst_read_addr%0d: got %h required addr %h read", b,
                     (acc_q.size() > b) ? acc_q[b] : '0, 32'h100 + 32'(4 * b));
         end
      end
   endtask

   task automatic test_strobe_read;
      rsp_t r, e;
      int   n, s0;
      push_read(32'h100, 4'h3, 0);
      send_cmd(32'h100, 1'b0, 4'h3, 2'd0);
      checks++;
      if (memStrb !== 4'h3) begin
         failures++;
         $display("FAIL issue_strobe: memStrb=%h required 3", memStrb);
      end
      n = 0;
      while (!rspValid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (n != 3) begin
         failures++;
         $display("FAIL read_latency: got %0d cycles required 3", n);
      end
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e || r.data !== 32'h0000BEEF) begin
         failures++;
         $display("FAIL strb3_read: got %h required %h", r, e);
      end
      s0 = strb_cycles;
      push_read(32'h100, 4'h0, 0);
      send_cmd(32'h100, 1'b0, 4'h0, 2'd0);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL strb0_read: got %h required %h", r, e);
      end
      checks++;
      if (strb_cycles != s0) begin
         failures++;
         $display("FAIL strb0_no_pulse: got %0d pulses required 0", strb_cycles - s0);
      end
      ref_write(32'h104, 4'h4, 32'h00770000);
      exp_q.push_back('{32'h0, 1'b1, 1'b1, 1'b0});
      send_cmd(32'h104, 1'b1, 4'h4, 2'd0);
      send_wdata(32'h00770000);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL lane_write_rsp: got %h required %h", r, e);
      end
      push_read(32'h104, 4'hF, 0);
      send_cmd(32'h104, 1'b0, 4'hF, 2'd0);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL lane_write_readback: got %h required %h", r, e);
      end
   endtask

   task automatic test_timeout;
      rsp_t r, e;
      int   n;
      busy_tie0 = 1'b1;
      exp_q.push_back('{32'h0, 1'b1, 1'b0, 1'b1});
      send_cmd(32'h200, 1'b0, 4'hF, 2'd1);
      n = 0;
      while (!rspValid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (n != TMO + 1) begin
         failures++;
         $display("FAIL timeout_latency: got %0d cycles required %0d", n, TMO + 1);
      end
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL timeout_rsp: got %h required %h", r, e);
      end
      checks++;
      if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_abort: reqReady=%b rspValid=%b required 1 0", reqReady, rspValid);
      end
      busy_tie0 = 1'b0;
   endtask

   task automatic test_stall;
      rsp_t        r, e;
      logic [67:0] held;
      int          n, s0;
      push_read(32'h100, 4'hF, 3);
      send_cmd(32'h100, 1'b0, 4'hF, 2'd3);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL stall_beat0: got %h required %h", r, e);
      end
      n = 0;
      while (!rspValid && n < 100) begin @(negedge clk); n++; end
      held = {rspData, rspLast, rspWr, rspErr, memAddr};
      s0 = strb_cycles;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (rspValid !== 1'b1 || memStrb !== 4'h0 ||
             {rspData, rspLast, rspWr, rspErr, memAddr} !== held) begin
            failures++;
            $display("FAIL stall_hold%0d: got v=%b strb=%h f=%h required 1 0 %h", c, rspValid,
                     memStrb, {rspData, rspLast, rspWr, rspErr, memAddr}, held);
         end
      end
      checks++;
      if (strb_cycles != s0) begin
         failures++;
         $display("FAIL stall_no_pulse: got %0d pulses required 0", strb_cycles - s0);
      end
      for (int b = 1; b < 4; b++) begin
         get_rsp(r);
         e = exp_q.pop_front();
         checks++;
         if (r !== e) begin
            failures++;
            $display("FAIL stall_beat%0d: got %h required %h", b, r, e);
         end
      end
   endtask

   task automatic test_wrap;
      rsp_t r, e;
      acc_q.delete();
      ref_write(32'hFFFFFFFC, 4'hF, 32'h11112222);
      ref_write(32'h00000000, 4'hF, 32'h33334444);
      exp_q.push_back('{32'h0, 1'b1, 1'b1, 1'b0});
      send_cmd(32'hFFFFFFFC, 1'b1, 4'hF, 2'd1);
      send_wdata(32'h11112222);
      send_wdata(32'h33334444);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL wrap_write_rsp: got %h required %h", r, e);
      end
      checks++;
      if (acc_q.size() != 2 || acc_q[0].addr !== 32'hFFFFFFFC || acc_q[1].addr !== 32'h0) begin
         failures++;
         $display("FAIL wrap_addr: got n=%0d last=%h required FFFFFFFC then 00000000",
                  acc_q.size(), (acc_q.size() > 0) ? acc_q[acc_q.size()-1].addr : 32'h0);
      end
      push_read(32'hFFFFFFFC, 4'hF, 1);
      send_cmd(32'hFFFFFFFC, 1'b0, 4'hF, 2'd1);
      for (int b = 0; b < 2; b++) begin
         get_rsp(r);
         e = exp_q.pop_front();
         checks++;
         if (r !== e) begin
            failures++;
            $display("FAIL wrap_read%0d: got %h required %h", b, r, e);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      rsp_t r, e;
      push_read(32'h100, 4'hF, 3);
      send_cmd(32'h100, 1'b0, 4'hF, 2'd3);
      get_rsp(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
         failures++;
         $display("FAIL midrst_beat0: got %h required %h", r, e);
      end
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL midrst_outputs: got %h required 0", all_out);
      end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (reqReady !== 1'b1) begin
         failures++;
         $display("FAIL midrst_ready: reqReady=%b required 1", reqReady);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (rspValid !== 1'b0 || memStrb !== 4'h0) begin
         failures++;
         $display("FAIL midrst_dropped: rspValid=%b memStrb=%h required 0 0", rspValid, memStrb);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_rw();
      test_strobe_read();
      test_timeout();
      test_stall();
      test_wrap();
      test_reset_mid_burst();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty: got %0d pending required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
